mux_scan_ctrl: RTL
==================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 2, SHALL set the cycles held per channel before sampling; legal range 1..15.
REQ-002 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 i_start  input  1  SHALL request one scan; sampled only in IDLE.
REQ-005 i_y1  input  1  SHALL carry the mux 1Y output.
REQ-006 i_y2  input  1  SHALL carry the mux 2Y output.
REQ-007 i_ready  input  1  SHALL be the consumer ready for the o_valid/o_word handshake.
REQ-008 o_sel_b  output  1  SHALL drive mux select B (channel MSB).
REQ-009 o_sel_a  output  1  SHALL drive mux select A (channel LSB).
REQ-010 o_g1_n  output  1  SHALL drive the active-low strobe of mux 1.
REQ-011 o_g2_n  output  1  SHALL drive the active-low strobe of mux 2.
REQ-012 o_word1  output  4  SHALL hold the captured mux 1 data; bit n = channel Cn.
REQ-013 o_word2  output  4  SHALL hold the captured mux 2 data; bit n = channel Cn.
REQ-014 o_valid  output  1  SHALL flag that o_word1/o_word2 hold a completed scan.
REQ-015 o_busy  output  1  SHALL be high in SCAN state.

Function
REQ-016 The FSM SHALL have states IDLE, SCAN and DONE; all outputs SHALL be registered.
REQ-017 IDLE: o_g1_n=o_g2_n=1 and sel=00; i_start=1 SHALL move the FSM to SCAN with ch=0 and the settle counter cleared.
REQ-018 SCAN: o_g1_n=o_g2_n=0, {o_sel_b,o_sel_a}=ch, and each channel SHALL be held for exactly SETTLE_CYC+1 cycles.
REQ-019 On the last edge of each channel slot, i_y1/i_y2 SHALL be captured into internal capture bit [ch], then ch SHALL increment.
REQ-020 After the ch=3 capture, the FSM SHALL enter DONE and load o_word1/o_word2 from capture in the same edge.
REQ-021 o_valid SHALL be high exactly in DONE.
REQ-022 Latency: o_valid SHALL first read 1 exactly 4*(SETTLE_CYC+1) cycles after the edge that sampled i_start (12 at default).
REQ-023 DONE: strobes SHALL be 1 and sel SHALL be 00; o_word1/o_word2 SHALL stay stable until the handshake.
REQ-024 o_valid&i_ready on an edge SHALL complete the transfer and return the FSM to IDLE.
REQ-025 o_word1/o_word2 SHALL keep their last value outside DONE; they change only on entry to DONE.
REQ-026 i_start in SCAN or DONE SHALL be ignored and SHALL NOT queue.
REQ-027 i_ready without o_valid SHALL have no effect.
REQ-028 ch SHALL never wrap within a scan; exactly four captures occur per scan.

Reset
REQ-029 On i_rst=1 at a clock edge, in any state including mid-scan, the FSM SHALL go to IDLE and ch/counter/capture SHALL be 0.
REQ-030 Reset values SHALL be: o_sel_b=0, o_sel_a=0, o_g1_n=1, o_g2_n=1, o_word1=0, o_word2=0, o_valid=0, o_busy=0.
REQ-031 i_rst SHALL take priority over i_start and i_ready in the same cycle.

Configuration
REQ-032 Macro MUX_SCAN_CONT_EN defined: a DONE handshake SHALL go straight to SCAN with ch=0 (continuous scanning), and i_start SHALL only start the first scan after reset.
REQ-033 MUX_SCAN_CONT_EN undefined: the DONE handshake SHALL return to IDLE per REQ-024.

Verification
REQ-034 SETTLE_CYC=2, mux model 1C=1010, 2C=0101, pulse i_start, i_ready=1 -> o_valid at cycle 12, o_word1=4'hA, o_word2=4'h5, one-cycle valid, then IDLE with strobes=1.
REQ-035 Select trace: during the scan -> sel=00,01,10,11 for 3 cycles each and strobes=0 throughout.
REQ-036 Backpressure: i_ready=0 for 5 cycles after o_valid -> o_valid and words held for 5 cycles; i_ready=1 -> valid drops the next cycle.
REQ-037 i_start pulsed at cycles 4 and 13 of a scan -> no restart, single o_valid, o_busy unaffected.
REQ-038 i_rst at cycle 7 of a scan -> next cycle all outputs at reset values; a new i_start -> full 12-cycle scan with correct words.
REQ-039 MUX_SCAN_CONT_EN defined, i_ready=1 -> o_valid every 13 cycles; changing 1C to 0011 -> next word1=4'h3.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a dual 4:1 mux pair: steps the selects over four channels and captures 1Y/2Y into two nibbles.
// Build option: define MUX_SCAN_CONT_EN to restart the scan after each handshake so scanning runs continuously.
module mux_scan_ctrl #(
  parameter int SETTLE_CYC = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_y1,
  input  logic       i_y2,
  input  logic       i_ready,
  output logic       o_sel_b,
  output logic       o_sel_a,
  output logic       o_g1_n,
  output logic       o_g2_n,
  output logic [3:0] o_word1,
  output logic [3:0] o_word2,
  output logic       o_valid,
  output logic       o_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC);

  logic [1:0] state, state_nxt;
  logic [1:0] ch, ch_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] cap1, cap1_nxt;
  logic [3:0] cap2, cap2_nxt;
  logic       load_word;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_nxt = state;
    ch_nxt    = ch;
    cnt_nxt   = cnt;
    cap1_nxt  = cap1;
    cap2_nxt  = cap2;
    load_word = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt = ST_SCAN;
          ch_nxt    = 2'd0;
          cnt_nxt   = 4'd0;
        end
      end
      ST_SCAN: begin
        if (cnt == CNT_LAST) begin
          cap1_nxt[ch] = i_y1;
          cap2_nxt[ch] = i_y2;
          cnt_nxt      = 4'd0;
          // ch stays at 3 after the last slot; it is only cleared when a new scan begins.
          if (ch == 2'd3) begin
            state_nxt = ST_DONE;
            load_word = 1'b1;
          end else begin
            ch_nxt = ch + 2'd1;
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
`ifdef MUX_SCAN_CONT_EN
          state_nxt = ST_SCAN;
          ch_nxt    = 2'd0;
          cnt_nxt   = 4'd0;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so it lives inside the clocked branch.
    if (i_rst) begin
      state   <= ST_IDLE;
      ch      <= 2'd0;
      cnt     <= 4'd0;
      cap1    <= 4'd0;
      cap2    <= 4'd0;
      o_sel_b <= 1'b0;
      o_sel_a <= 1'b0;
      o_g1_n  <= 1'b1;
      o_g2_n  <= 1'b1;
      o_word1 <= 4'd0;
      o_word2 <= 4'd0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ch      <= ch_nxt;
      cnt     <= cnt_nxt;
      cap1    <= cap1_nxt;
      cap2    <= cap2_nxt;
      o_sel_b <= (state_nxt == ST_SCAN) ? ch_nxt[1] : 1'b0;
      o_sel_a <= (state_nxt == ST_SCAN) ? ch_nxt[0] : 1'b0;
      o_g1_n  <= (state_nxt != ST_SCAN);
      o_g2_n  <= (state_nxt != ST_SCAN);
      o_valid <= (state_nxt == ST_DONE);
      o_busy  <= (state_nxt == ST_SCAN);
      if (load_word) begin
        o_word1 <= cap1_nxt;
        o_word2 <= cap2_nxt;
      end
    end
  end

endmodule
